// File: rtl/sfifo_drain.sv
// Read-side master for a synchronous FIFO with registered-request read timing.
// Requests are credit-limited so honoured words always fit the local buffer.
module sfifo_drain #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_r_en,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              miss,
  output logic              idle
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned CRD_W = PTR_W + 3;

  logic              r_en_q, r_en_d;
  logic              s1_q, s1_d;
  logic              s2_q, s2_d;
  logic              miss_q, miss_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic             push;
  logic             pop;
  logic [CRD_W-1:0] credit;

  assign push = s2_q;
  assign pop  = m_valid & m_ready;

  // Buffered words plus every request that may still turn into a word.
  assign credit = CRD_W'(occ_q) - CRD_W'(pop) + CRD_W'(r_en_q)
                + CRD_W'(s1_q) + CRD_W'(s2_q);

  always_comb begin
    r_en_d   = en & ~fifo_empty & (credit < CRD_W'(DEPTH));
    s1_d     = r_en_q;
    s2_d     = s1_q & ~fifo_empty;
    miss_d   = s1_q & fifo_empty;
    occ_d    = occ_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d    = cnt_q + CNT_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en_q   <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      miss_q   <= 1'b0;
      occ_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      r_en_q   <= r_en_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      miss_q   <= miss_d;
      occ_q    <= occ_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= fifo_dout;
      end
    end
  end

  assign fifo_r_en = r_en_q;
  assign m_valid   = (occ_q != '0);
  assign m_data    = mem_q[rd_ptr_q];
  assign word_cnt  = cnt_q;
  assign miss      = miss_q;
  assign idle      = ~en & ~r_en_q & ~s1_q & ~s2_q & (occ_q == '0);

endmodule

// File: tb/tb_sfifo_drain.sv
// Bench for sfifo_drain: behavioural FIFO with registered-request reads,
// scoreboard of written words, and a negedge monitor checking every output.
module tb_sfifo_drain;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, en, fifo_empty, fifo_r_en, m_valid, m_ready, miss, idle;
  logic [7:0] fifo_dout, m_data;
  logic [15:0] word_cnt;
  logic       wr_en;
  logic [7:0] wr_data;

  sfifo_drain #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_r_en(fifo_r_en), .m_valid(m_valid),
    .m_data(m_data), .m_ready(m_ready), .word_cnt(word_cnt),
    .miss(miss), .idle(idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Behavioural FIFO and scoreboard
  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  logic       r_en_reg, exp_miss;
  int         popped_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fq.delete();
      exp_q.delete();
      r_en_reg   <= 1'b0;
      exp_miss   <= 1'b0;
      fifo_empty <= 1'b1;
      fifo_dout  <= '0;
      popped_cnt = 0;
    end else begin
      r_en_reg <= fifo_r_en;
      exp_miss <= r_en_reg && fifo_empty;
      if (r_en_reg && !fifo_empty) begin
        fifo_dout <= fq.pop_front();
        popped_cnt++;
      end
      if (wr_en) begin
        fq.push_back(wr_data);
        exp_q.push_back(wr_data);
      end
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Monitor
  int   cyc = 0;
  int   acc_cnt, miss_cnt, ren_cnt, early_miss;
  int   t_fall, t_valid, first_acc, last_acc, last_miss, last_ren, t3_base;
  logic t3_mode = 1'b0;
  logic prev_empty = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      chk("miss", miss, exp_miss);
      chk("occ_bound", (popped_cnt - acc_cnt) <= DEPTH, 1);
      if (miss) begin
        miss_cnt++;
        last_miss = cyc;
        if (t3_mode && (popped_cnt - t3_base) < 64) early_miss++;
      end
      if (fifo_r_en) begin
        ren_cnt++;
        last_ren = cyc;
      end
      if (prev_empty && !fifo_empty && t_fall < 0) t_fall = cyc;
      if (m_valid && t_valid < 0) t_valid = cyc;
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          chk("m_data", m_data, exp_q[0]);
          if (m_ready) begin
            void'(exp_q.pop_front());
            acc_cnt++;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
          end
        end
      end
    end
    prev_empty = fifo_empty;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic clr_marks();
    t_fall = -1; t_valid = -1; first_acc = -1; last_acc = -1;
    last_miss = -1; last_ren = -1; miss_cnt = 0; ren_cnt = 0; early_miss = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b0; m_ready = 1'b0; wr_en = 1'b0; wr_data = '0;
    acc_cnt = 0;
    clr_marks();
    #2;
    chk("rst_fifo_r_en", fifo_r_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_miss", miss, 0);
    chk("rst_idle", idle, 1);
    tick(); tick();
    rst = 1'b1;
    tick();

    // T1: three words, latency and back-to-back delivery
    en = 1'b1; m_ready = 1'b1; clr_marks();
    put(8'h11); put(8'h22); put(8'h33);
    repeat (12) tick();
    chk("t1_latency", t_valid - t_fall, 4);
    chk("t1_consecutive", last_acc - first_acc, 2);
    chk("t1_word_cnt", word_cnt, 3);
    chk("t1_idle_busy", idle, 0);

    // T2: single word tail
    clr_marks();
    put(8'hA5);
    repeat (12) tick();
    chk("t2_word_cnt", word_cnt, 4);
    chk("t2_miss_seen", miss_cnt != 0, 1);
    chk("t2_miss_delay", last_miss - last_ren, 2);
    en = 1'b0;
    repeat (4) tick();
    chk("t2_idle", idle, 1);
    chk("t2_scoreboard_empty", exp_q.size(), 0);

    // T3: 64 random words, m_ready toggling
    en = 1'b1; clr_marks(); t3_base = popped_cnt; t3_mode = 1'b1;
    for (int i = 0; i < 64; i++) begin
      m_ready = ~m_ready;
      wr_en = 1'b1;
      wr_data = 8'($urandom);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 120; i++) begin
      m_ready = ~m_ready;
      tick();
    end
    t3_mode = 1'b0;
    chk("t3_word_cnt", word_cnt, 68);
    chk("t3_early_miss", early_miss, 0);
    en = 1'b0; m_ready = 1'b1;
    repeat (6) tick();

    // T4: consumer stall with 10 words queued
    for (int i = 0; i < 10; i++) put(8'h40 + 8'(i));
    t3_base = popped_cnt;
    en = 1'b1; m_ready = 1'b0;
    repeat (20) tick();
    chk("t4_buffered", popped_cnt - t3_base, 4);
    chk("t4_r_en_low", fifo_r_en, 0);
    chk("t4_fifo_left", fq.size(), 6);
    chk("t4_valid", m_valid, 1);
    chk("t4_head", m_data, 8'h40);
    m_ready = 1'b1;
    repeat (20) tick();
    chk("t4_word_cnt", word_cnt, 78);
    en = 1'b0;
    repeat (6) tick();

    // T5: en dropped with two requests pending
    for (int i = 0; i < 8; i++) put(8'h80 + 8'(i));
    clr_marks();
    en = 1'b1;
    tick(); tick();
    en = 1'b0;
    repeat (10) tick();
    chk("t5_requests", ren_cnt, 2);
    chk("t5_word_cnt", word_cnt, 80);
    chk("t5_fifo_left", fq.size(), 6);
    chk("t5_idle", idle, 1);
    en = 1'b1;
    repeat (20) tick();
    en = 1'b0;
    repeat (5) tick();
    chk("t5_drain_cnt", word_cnt, 86);
    chk("t5_scoreboard_empty", exp_q.size(), 0);

    // T6: asynchronous reset while a word is presented
    for (int i = 0; i < 10; i++) put(8'hC0 + 8'(i));
    en = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 20 && !m_valid; i++) tick();
    chk("t6_valid_before_rst", m_valid, 1);
    @(negedge clk);
    #2;
    en = 1'b0;
    rst = 1'b0;
    acc_cnt = 0;
    #1;
    chk("t6_fifo_r_en", fifo_r_en, 0);
    chk("t6_m_valid", m_valid, 0);
    chk("t6_m_data", m_data, 0);
    chk("t6_word_cnt", word_cnt, 0);
    chk("t6_miss", miss, 0);
    chk("t6_idle", idle, 1);
    tick();
    rst = 1'b1; en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 5; i++) put(8'hD0 + 8'(i));
    repeat (15) tick();
    chk("t6_word_cnt_after", word_cnt, 5);
    chk("t6_scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
